// File: rtl/ii_pkg.sv
// Shared integral-image constants, corner-slot type and helpers used by the
// capture, display and rectangle-sum clients of the integral image buffer.
package ii_pkg;

    localparam int IMG_W          = 160;
    localparam int IMG_H          = 120;
    localparam int ADDR_W         = 15;
    localparam int DATA_W         = 20;
    localparam int RD_LATENCY_DEF = 2;
    localparam int COL_W          = 8;
    localparam int ROW_W          = 7;
    localparam int XE_W           = COL_W + 1;
    localparam int YE_W           = ROW_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_RD1   = 3'd2,
        ST_RD2   = 3'd3,
        ST_RD3   = 3'd4,
        ST_DRAIN = 3'd5
    } rect_state_e;

    // One corner lookup: position, whether it is read, and whether it subtracts.
    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic             en;
        logic             sub;
    } corner_t;

    function automatic logic [ADDR_W-1:0] ii_addr(input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] row);
        return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    endfunction

    // Right/bottom edges are compared one bit wider so oversize requests cannot wrap.
    function automatic logic rect_ok(input logic [COL_W-1:0] x,
                                     input logic [ROW_W-1:0] y,
                                     input logic [COL_W-1:0] w,
                                     input logic [ROW_W-1:0] h);
        logic [XE_W-1:0] x_end;
        logic [YE_W-1:0] y_end;
        x_end = {1'b0, x} + {1'b0, w};
        y_end = {1'b0, y} + {1'b0, h};
        return (w != {COL_W{1'b0}}) && (h != {ROW_W{1'b0}}) &&
               (x_end <= XE_W'(IMG_W)) && (y_end <= YE_W'(IMG_H));
    endfunction

endpackage

// File: rtl/ii_addr_gen.sv
// Buffer address generator: row*160+col built from shifts, with one register
// stage so rd_en/rd_addr leave the block registered.
module ii_addr_gen
    import ii_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr
);

    logic [ADDR_W-1:0] addr_s;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;

    // row*128 + row*32 + col
    always_comb begin
        addr_s = ADDR_W'({row, 7'd0}) + ADDR_W'({row, 5'd0}) + ADDR_W'(col);
    end

    // Registered strobe; the address bus is parked at zero for skipped slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
        end else begin
            rd_en_r   <= en;
            rd_addr_r <= en ? addr_s : {ADDR_W{1'b0}};
        end
    end

    assign rd_en   = rd_en_r;
    assign rd_addr = rd_addr_r;

endmodule

// File: rtl/ii_rect_sum.sv
// Rectangle sum over the integral image: four corner reads D,B,C,A with a
// {en,sign} tag pipe aligned to the buffer read latency, then one result strobe.
module ii_rect_sum
    import ii_pkg::*;
#(
    parameter int RD_LATENCY = RD_LATENCY_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [COL_W-1:0]  req_x,
    input  logic [ROW_W-1:0]  req_y,
    input  logic [COL_W-1:0]  req_w,
    input  logic [ROW_W-1:0]  req_h,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              sum_valid,
    output logic [DATA_W-1:0] sum,
    output logic              sum_err
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    rect_state_e       state_r, next_state_s;
    logic              accept_s;
    logic              finish_s;
    logic              req_ok_s;
    logic [COL_W-1:0]  x1_in_s;
    logic [ROW_W-1:0]  y1_in_s;
    corner_t           corner_s;

    logic [COL_W-1:0]  xm_r, x1_r;
    logic [ROW_W-1:0]  ym_r, y1_r;
    logic              mask_x_r, mask_y_r;
    logic              err_r;
    logic [CNT_W-1:0]  cnt_r;

    logic                  slot_sub_r;
    logic [RD_LATENCY-1:0] tag_en_r;
    logic [RD_LATENCY-1:0] tag_sub_r;
    logic [DATA_W-1:0]     acc_r, acc_next_s;

    logic              sum_valid_r;
    logic              sum_err_r;
    logic [DATA_W-1:0] sum_r;

    // Request decode; D corner is formed straight from the inputs in the accept cycle.
    always_comb begin
        req_ok_s = rect_ok(req_x, req_y, req_w, req_h);
        x1_in_s  = req_x + req_w - 8'd1;
        y1_in_s  = req_y + req_h - 7'd1;
    end

    // Next state and the corner presented to the address generator this cycle.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        corner_s     = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_ok_s) begin
                        next_state_s = ST_RD0;
                        corner_s     = '{col: x1_in_s, row: y1_in_s, en: 1'b1, sub: 1'b0};
                    end else begin
                        next_state_s = ST_DRAIN;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD0: begin
                next_state_s = ST_RD1;
                corner_s     = '{col: xm_r, row: y1_r, en: !mask_x_r, sub: 1'b1};
            end
            ST_RD1: begin
                next_state_s = ST_RD2;
                corner_s     = '{col: x1_r, row: ym_r, en: !mask_y_r, sub: 1'b1};
            end
            ST_RD2: begin
                next_state_s = ST_RD3;
                corner_s     = '{col: xm_r, row: ym_r, en: !mask_x_r && !mask_y_r, sub: 1'b0};
            end
            ST_RD3: begin
                next_state_s = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = ST_IDLE;
                    finish_s     = !err_r;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand latch: the x-1 / y-1 corners are masked rather than read when on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            xm_r     <= {COL_W{1'b0}};
            x1_r     <= {COL_W{1'b0}};
            ym_r     <= {ROW_W{1'b0}};
            y1_r     <= {ROW_W{1'b0}};
            mask_x_r <= 1'b0;
            mask_y_r <= 1'b0;
            err_r    <= 1'b0;
        end else if (accept_s) begin
            xm_r     <= req_x - 8'd1;
            x1_r     <= x1_in_s;
            ym_r     <= req_y - 7'd1;
            y1_r     <= y1_in_s;
            mask_x_r <= (req_x == 8'd0);
            mask_y_r <= (req_y == 7'd0);
            err_r    <= !req_ok_s;
        end
    end

    // Drain counter covers the read latency after the last corner slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_RD3) begin
            cnt_r <= CNT_W'(RD_LATENCY - 1);
        end else if ((state_r == ST_DRAIN) && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    ii_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (corner_s.en),
        .col     (corner_s.col),
        .row     (corner_s.row),
        .rd_en   (rd_en),
        .rd_addr (rd_addr)
    );

    // Tag pipe: the sign rides one stage with the address register, then RD_LATENCY more.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_sub_r <= 1'b0;
            tag_en_r   <= {RD_LATENCY{1'b0}};
            tag_sub_r  <= {RD_LATENCY{1'b0}};
        end else begin
            slot_sub_r   <= corner_s.sub;
            tag_en_r[0]  <= rd_en;
            tag_sub_r[0] <= slot_sub_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_en_r[i]  <= tag_en_r[i-1];
                tag_sub_r[i] <= tag_sub_r[i-1];
            end
        end
    end

    // Modulo-2^DATA_W accumulate; partial results may wrap, the final one cannot.
    always_comb begin
        acc_next_s = acc_r;
        if (tag_en_r[RD_LATENCY-1]) begin
            if (tag_sub_r[RD_LATENCY-1]) begin
                acc_next_s = acc_r - rd_data;
            end else begin
                acc_next_s = acc_r + rd_data;
            end
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Accumulator, cleared on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            acc_r <= {DATA_W{1'b0}};
        end else begin
            acc_r <= acc_next_s;
        end
    end

    // Result strobe; sum holds its value between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_valid_r <= 1'b0;
            sum_err_r   <= 1'b0;
            sum_r       <= {DATA_W{1'b0}};
        end else if (accept_s && !req_ok_s) begin
            sum_valid_r <= 1'b1;
            sum_err_r   <= 1'b1;
            sum_r       <= {DATA_W{1'b0}};
        end else if (finish_s) begin
            sum_valid_r <= 1'b1;
            sum_err_r   <= 1'b0;
            sum_r       <= acc_next_s;
        end else begin
            sum_valid_r <= 1'b0;
            sum_err_r   <= 1'b0;
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign sum_valid = sum_valid_r;
    assign sum_err   = sum_err_r;
    assign sum       = sum_r;

endmodule

// File: tb/tb_ii_rect_sum.sv
// Bench for ii_rect_sum: BRAM model with 2-cycle read latency, per-cycle schedule
// of expected outputs derived from brute-force rectangle sums.
module tb_ii_rect_sum;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int LAT  = 2;
    localparam int NCYC = 8192;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, rd_en, sum_valid, sum_err;
    logic [7:0]  req_x, req_w;
    logic [6:0]  req_y, req_h;
    logic [14:0] rd_addr;
    logic [19:0] rd_data, bram_p1, sum;

    always #5 clk = ~clk;

    ii_rect_sum #(.RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .sum_valid(sum_valid), .sum(sum), .sum_err(sum_err)
    );

    int          pix  [W][H];
    int          iimg [W][H];
    logic [19:0] mem  [W*H];

    // Buffer port B: junk on the bus for any slot that was not read.
    always @(posedge clk) begin
        bram_p1 <= (rd_en && (rd_addr < 15'd19200)) ? mem[rd_addr] : 20'hABCDE;
        rd_data <= bram_p1;
    end

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    bit armed = 1'b0;
    int armed_from = 0;
    bit accepted_now;
    int last_acc;
    int held_sum = 0;
    int dut_last_sum = -1, dut_last_err = -1, dut_sv_cyc = -1;

    bit exp_rd_en [NCYC];
    int exp_addr  [NCYC];
    bit exp_busy  [NCYC];
    bit exp_sv    [NCYC];
    bit exp_err   [NCYC];
    bit exp_zero  [NCYC];
    int exp_sum   [NCYC];

    task automatic check(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, expv);
        end
    endtask

    task automatic build_image(input bit rnd, input int val);
        for (int c = 0; c < W; c++)
            for (int r = 0; r < H; r++)
                pix[c][r] = rnd ? int'($urandom_range(0, 15)) : val;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                iimg[c][r] = pix[c][r];
                if (c > 0) iimg[c][r] += iimg[c-1][r];
                if (r > 0) iimg[c][r] += iimg[c][r-1];
                if (c > 0 && r > 0) iimg[c][r] -= iimg[c-1][r-1];
                mem[r*W + c] = 20'(iimg[c][r]);
            end
    endtask

    function automatic int brute(input int x, input int y, input int w, input int h);
        int s = 0;
        for (int c = x; c < x + w; c++)
            for (int r = y; r < y + h; r++)
                s += pix[c][r];
        return s;
    endfunction

    task automatic clear_after(input int from);
        for (int i = from; i < NCYC; i++) begin
            exp_rd_en[i] = 1'b0; exp_addr[i] = 0; exp_busy[i] = 1'b0;
            exp_sv[i] = 1'b0; exp_err[i] = 1'b0; exp_zero[i] = 1'b0; exp_sum[i] = 0;
        end
    endtask

    task automatic schedule(input int t, input int x, input int y, input int w, input int h);
        int cols [4];
        int rows [4];
        bit ok;
        ok = (w != 0) && (h != 0) && (x + w <= W) && (y + h <= H);
        if (!ok) begin
            exp_busy[t+1] = 1'b1;
            exp_sv[t+1]   = 1'b1;
            exp_err[t+1]  = 1'b1;
            exp_sum[t+1]  = 0;
        end else begin
            cols = '{x + w - 1, x - 1, x + w - 1, x - 1};
            rows = '{y + h - 1, y + h - 1, y - 1, y - 1};
            for (int i = 0; i < 4; i++) begin
                exp_rd_en[t+1+i] = (cols[i] >= 0) && (rows[i] >= 0);
                exp_addr[t+1+i]  = exp_rd_en[t+1+i] ? rows[i] * W + cols[i] : 0;
            end
            for (int i = t + 1; i <= t + 4 + LAT; i++) exp_busy[i] = 1'b1;
            exp_sv[t+5+LAT]  = 1'b1;
            exp_err[t+5+LAT] = 1'b0;
            exp_sum[t+5+LAT] = brute(x, y, w, h);
        end
    endtask

    task automatic compare_outputs();
        if (armed && cyc >= armed_from) begin
            check("rd_en", int'(rd_en), int'(exp_rd_en[cyc]));
            check("rd_addr", int'(rd_addr), exp_addr[cyc]);
            check("req_ready", int'(req_ready), int'(!exp_busy[cyc]));
            check("sum_valid", int'(sum_valid), int'(exp_sv[cyc]));
            if (exp_zero[cyc]) held_sum = 0;
            if (exp_sv[cyc]) begin
                held_sum = exp_sum[cyc];
                check("sum_err", int'(sum_err), int'(exp_err[cyc]));
            end
            check("sum", int'(sum), held_sum);
            if (sum_valid) begin
                dut_last_sum = int'(sum);
                dut_last_err = int'(sum_err);
                dut_sv_cyc   = cyc;
            end
        end
    endtask

    task automatic model_eval();
        accepted_now = 1'b0;
        if (rst) begin
            clear_after(cyc + 1);
            exp_zero[cyc+1] = 1'b1;
            if (!armed) begin
                armed = 1'b1;
                armed_from = cyc + 1;
            end
        end else if (armed && req_valid && !exp_busy[cyc]) begin
            accepted_now = 1'b1;
            last_acc = cyc;
            schedule(cyc, int'(req_x), int'(req_y), int'(req_w), int'(req_h));
        end
    endtask

    task automatic cycle_end();
        @(negedge clk);
        compare_outputs();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle_end();
    endtask

    task automatic drive_req(input int x, input int y, input int w, input int h,
                             input bit keep, output int acc_cyc);
        int n = 0;
        req_valid = 1'b1;
        req_x = 8'(x); req_y = 7'(y); req_w = 8'(w); req_h = 7'(h);
        do begin
            cycle_end();
            n++;
        end while (!accepted_now && n < 40);
        if (!accepted_now) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout cyc=%0d got=not accepted expected=accepted", cyc);
        end
        acc_cyc = last_acc;
        if (!keep) begin
            req_valid = 1'b0;
            req_x = 8'($urandom); req_y = 7'($urandom);
            req_w = 8'($urandom); req_h = 7'($urandom);
        end
    endtask

    initial begin
        int t1, t2;
        rst = 1'b1; req_valid = 1'b0;
        req_x = 8'd0; req_y = 7'd0; req_w = 8'd0; req_h = 7'd0;
        clear_after(0);
        build_image(1'b0, 1);
        @(posedge clk);
        #1;
        run(2);
        rst = 1'b0;
        run(2);

        // 1: unit image, interior rectangle
        check("pin_ii_17_23", iimg[17][23], 432);
        check("pin_brute_t1", brute(10, 20, 8, 4), 32);
        drive_req(10, 20, 8, 4, 1'b0, t1);
        run(9);
        check("t1_sum", dut_last_sum, 32);
        check("t1_latency", dut_sv_cyc - t1, 7);

        // 2: full frame of 15s
        build_image(1'b0, 15);
        check("pin_brute_t2", brute(0, 0, 160, 120), 288000);
        drive_req(0, 0, 160, 120, 1'b0, t1);
        run(9);
        check("t2_sum", dut_last_sum, 288000);

        // 3: left edge masks B and A
        build_image(1'b0, 1);
        check("pin_brute_t3", brute(0, 5, 3, 2), 6);
        drive_req(0, 5, 3, 2, 1'b0, t1);
        run(9);
        check("t3_sum", dut_last_sum, 6);

        // 4: rejected requests
        drive_req(155, 30, 10, 5, 1'b0, t1);
        run(3);
        check("t4a_err", dut_last_err, 1);
        check("t4a_latency", dut_sv_cyc - t1, 1);
        drive_req(20, 20, 0, 5, 1'b0, t1);
        run(3);
        check("t4b_err", dut_last_err, 1);
        check("t4b_sum", dut_last_sum, 0);

        // 5: back-to-back with req_valid held
        drive_req(3, 7, 20, 11, 1'b1, t1);
        drive_req(40, 0, 33, 9, 1'b0, t2);
        check("t5_gap", t2 - t1, 7);
        run(9);

        // 6: reset at T+3 aborts the request
        drive_req(30, 40, 20, 10, 1'b0, t1);
        run(2);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(8);
        drive_req(31, 41, 5, 6, 1'b0, t1);
        run(9);
        check("t6_sum", dut_last_sum, 30);

        // Random rectangles, gaps, back-to-back and reset collisions
        build_image(1'b1, 0);
        run(10);
        for (int it = 0; it < 220 && cyc < NCYC - 200; it++) begin
            int x, y, w, h;
            bit keep;
            x = $urandom_range(0, 165);
            y = $urandom_range(0, 125);
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 170) : $urandom_range(1, 30);
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(1, 25);
            keep = ($urandom_range(0, 3) == 0);
            drive_req(x, y, w, h, keep, t1);
            if (!keep) run($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) begin
                run($urandom_range(0, 6));
                req_valid = 1'b1;
                rst = 1'b1;
                run(1);
                rst = 1'b0;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        run(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
